// File: rtl/video_in_wb_writer.sv
// video_in_wb_writer: pops full packets from the video-input FIFO and writes them to the frame buffer as Wishbone bursts
// Ports: clk/nRST clock and async active-low reset; fifo_data/nb_pack_available/fifo_r_ack FIFO read side;
// base_addr frame-buffer byte base; wb_* Wishbone classic master; frame_done one-cycle end-of-frame pulse.
// Option: VIDEO_IN_WB_CTI_EN adds wb_cti_o (incrementing-burst cycle type tags).
module video_in_wb_writer #(
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 76800,
  parameter int RD_LAT      = 2
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] fifo_data,
  input  logic        nb_pack_available,
  output logic        fifo_r_ack,
  input  logic [31:0] base_addr,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_ack_i,
`ifdef VIDEO_IN_WB_CTI_EN
  output logic [2:0]  wb_cti_o,
`endif
  output logic        frame_done
);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int OW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;
  state_t state, state_nx;
  logic [1:0] fcnt;
  logic [BW-1:0] beat;
  logic [OW-1:0] offset;
  logic [31:0] frame_base;
  logic loaded;
  logic fetch_last, beat_last, word_last, ack;
  assign fetch_last = state == FETCH && fcnt == 2'(RD_LAT - 1);
  assign beat_last = beat == BW'(BURST_LEN - 1);
  assign word_last = offset == OW'(FRAME_WORDS - 1);
  assign ack = state == WRITE && wb_ack_i;
  assign fifo_r_ack = ack;
  assign wb_stb_o = state == WRITE;
  assign wb_we_o = wb_stb_o;
  // cycle stays open across the inter-beat fetches; the first fetch of a burst has beat == 0
  assign wb_cyc_o = wb_stb_o || (state == FETCH && beat != '0);
  assign wb_sel_o = 4'hF;
`ifdef VIDEO_IN_WB_CTI_EN
  assign wb_cti_o = !wb_stb_o ? 3'b000 : beat_last ? 3'b111 : 3'b010;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (nb_pack_available) state_nx = FETCH;
      FETCH:   if (fetch_last) state_nx = WRITE;
      WRITE:   if (wb_ack_i) state_nx = beat_last ? IDLE : FETCH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      fcnt <= '0;
      beat <= '0;
      offset <= '0;
      frame_base <= '0;
      loaded <= 1'b0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= ack && word_last;
      fcnt <= state == FETCH && !fetch_last ? fcnt + 2'd1 : 2'd0;
      // first edge after reset release picks up the base for the first frame
      if (!loaded) begin
        frame_base <= base_addr & 32'hFFFF_FFFC;
        loaded <= 1'b1;
      end
      // address and data are registered together so they stay stable through slave wait states
      if (fetch_last) begin
        wb_dat_o <= fifo_data;
        wb_adr_o <= frame_base + 32'({offset, 2'b00});
      end
      if (ack) begin
        beat <= beat_last ? '0 : beat + BW'(1);
        offset <= word_last ? '0 : offset + OW'(1);
        if (word_last) frame_base <= base_addr & 32'hFFFF_FFFC;
      end
    end
  end
endmodule

// File: doc/video_in_wb_writer.md
# video_in_wb_writer

Downstream consumer of the video-input FIFO: waits until the FIFO reports a full packet available, pops it word by word and writes it to the frame buffer as a Wishbone master burst. Byte addresses advance linearly from a programmable base and wrap to the base after one frame. Sits between the video-input FIFO (`data_out`, `r_ack`, `nb_pack_available`) and the system Wishbone interconnect.

## Interface
- `BURST_LEN`, 16: words per burst; equals the FIFO's packet threshold.
- `FRAME_WORDS`, 76800: 32-bit words per frame (320x240 pixels, 1 word per pixel); must be a multiple of `BURST_LEN`.
- `RD_LAT`, 2: cycles after a pop before `fifo_data` shows the new head word (synchronous RAM read); range 1..3.
- `clk`  in  1  single system clock, rising edge.
- `nRST`  in  1  asynchronous reset, active low.
- `fifo_data`  in  32  FIFO head word.
- `nb_pack_available`  in  1  FIFO holds at least `BURST_LEN` words.
- `fifo_r_ack`  out  1  pop strobe to the FIFO; one pulse per word.
- `base_addr`  in  32  frame-buffer byte base address; bits [1:0] ignored.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1 each  Wishbone classic master strobes.
- `wb_adr_o`  out  32  byte address.
- `wb_dat_o`  out  32  write data.
- `wb_sel_o`  out  4  constant 4'hF.
- `wb_ack_i`  in  1  slave acknowledge.
- `frame_done`  out  1  one-cycle pulse after the last word of a frame is acked.

## Operation
- FSM states:
  - IDLE: `wb_cyc_o`=0. Moves to FETCH when `nb_pack_available`=1.
  - FETCH: lasts exactly `RD_LAT` cycles, `wb_stb_o`=0. In the last cycle, `fifo_data` is latched into `wb_dat_o`, and the state moves to WRITE.
  - WRITE: `wb_cyc_o`=`wb_stb_o`=`wb_we_o`=1. Holds until `wb_ack_i`.
    - On ack: `fifo_r_ack`=1 in that same cycle (combinational: WRITE & `wb_ack_i`).
    - The beat counter increments and the word offset increments.
    - Next state is FETCH if beats remain, otherwise IDLE.
- `wb_cyc_o` rises on entering the first WRITE and stays high through inter-beat FETCH cycles. It falls in the cycle after the last ack.
- Address: `wb_adr_o` = `frame_base` + 4·`offset`.
  - `offset` is a ceil(log2(`FRAME_WORDS`))-bit counter.
  - `frame_base` is captured from `base_addr` at reset release and again at every frame wrap.
  - Arithmetic is modulo 2^32.
- Wrap: when the ack of word `FRAME_WORDS`-1 arrives, `offset`←0, `frame_base`←`base_addr`, and `frame_done` pulses in the next cycle.
- `nb_pack_available` is sampled only in IDLE; a drop mid-burst is ignored, because the FIFO already holds the packet.
- `wb_ack_i` outside WRITE is ignored and causes no pop.
- Reset mid-burst: all state returns to IDLE immediately and `wb_cyc_o` drops asynchronously. Unacked words are lost; the FIFO is reset by the same `nRST`.

## Timing
- Reset values: `wb_cyc_o`/`wb_stb_o`/`wb_we_o`=0, `wb_adr_o`=0, `wb_dat_o`=0, `wb_sel_o`=4'hF, `fifo_r_ack`=0, `frame_done`=0, `wb_cti_o`=3'b000.
- Start latency: `nb_pack_available` seen in IDLE at cycle t gives first `wb_stb_o` at t+1+`RD_LAT`.
- Beat period with a zero-wait slave: `RD_LAT`+1 cycles.
- Full burst: `BURST_LEN`·(`RD_LAT`+1) cycles, plus 1 IDLE cycle before the next burst can start.
- Slave wait states stretch WRITE only; `wb_adr_o`/`wb_dat_o` are stable while `wb_stb_o`=1.

## Configuration
- `VIDEO_IN_WB_CTI_EN` defined: adds output `wb_cti_o` [2:0].
  - 3'b010 (incrementing burst) on every WRITE except the last beat.
  - 3'b111 on the last beat.
  - 3'b000 otherwise.
- `VIDEO_IN_WB_CTI_EN` undefined: the port is absent; the block is classic-cycle only. Behaviour is otherwise identical.

## Test plan
- **Reset release, FIFO idle:** all outputs hold their reset values; no `wb_cyc_o` for 100 cycles.
- **Single packet** (`base_addr`=0x1000_0000, zero-wait slave, words 0..15):
  - 16 writes at addresses 0x1000_0000..0x1000_003C with matching data.
  - Exactly 16 `fifo_r_ack` pulses; strobe spacing 3 cycles.
- **Slave inserts 2 wait states per beat:** data/address held stable; one pop per ack; burst length 16·5 cycles.
- **`FRAME_WORDS`=32, three packets, `base_addr` changed to 0x2000_0000 mid-frame:**
  - Packet 3 starts at 0x2000_0000.
  - `frame_done` pulses once, after the ack of word 31.
- **`nRST` asserted during beat 7 of a burst:** `wb_cyc_o`=0 immediately; after release the next burst restarts at the captured base.
- **`VIDEO_IN_WB_CTI_EN` defined:** `wb_cti_o`=010 for beats 0..14, 111 for beat 15, 000 in IDLE.
